decode_sequencer: RTL
=====================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 Parameter: XLEN, 32, instruction and PC width.
REQ-002 Parameter: BUF_DEPTH, 2, instruction buffer entries (fixed at 2).
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Ports: clk  in  1  rising-edge clock.
REQ-005 Ports: rst_n  in  1  asynchronous active-low reset.
REQ-006 Ports: fetch_valid  in  1; fetch_instr  in  XLEN; fetch_pc  in  XLEN; fetch_ready  out  1. These form the fetch-side valid/ready push.
REQ-007 Ports: dec_en  out  1; dec_instr  out  XLEN. These drive the instruction decoder's en and instruction_code.
REQ-008 Ports: dec_invalid  in  32; dec_jmp_op  in  9; dec_csr_op  in  6; dec_mechie_op  in  8. These are combinational decoder outputs for dec_instr.
REQ-009 Ports: issue_valid  out  1; issue_ready  in  1; issue_pc  out  XLEN; issue_instr  out  XLEN. These form the execute-side handshake.
REQ-010 Ports: exec_done  in  1. Single-cycle completion of a serializing instruction.
REQ-011 Ports: flush  in  1. Pipeline redirect that discards all buffered and in-flight instructions.
REQ-012 Ports: trap_req  out  1; trap_pc  out  XLEN. These report an illegal instruction.
REQ-013 Ports: issue_cnt  out  32. Count of completed issue handshakes.

Function
REQ-014 The instruction buffer SHALL be a 2-entry FIFO of {pc, instr}.
REQ-015 A push SHALL occur on fetch_valid && fetch_ready.
REQ-016 fetch_ready SHALL be (count<2) && !flush.
REQ-017 The FSM states SHALL be IDLE, DECODE, ISSUE, SERIAL, TRAP.
REQ-018 IDLE: if the FIFO is non-empty, the sequencer SHALL pop the head into the dec_instr/pc register and go to DECODE; otherwise it stays in IDLE.
REQ-019 DECODE: dec_en SHALL be 1 for exactly this cycle, and classification SHALL be sampled at the end of it.
REQ-020 DECODE transitions: dec_invalid!=0 -> TRAP; else -> ISSUE, with the serializing flag latched.
REQ-021 The serializing flag SHALL be set when dec_jmp_op!=0, dec_csr_op!=0 or dec_mechie_op!=0.
REQ-022 ISSUE: issue_valid=1, and issue_pc/issue_instr SHALL stay stable until issue_ready.
REQ-023 On the ISSUE handshake: if serializing -> SERIAL; else if FIFO non-empty -> pop and go to DECODE directly; else -> IDLE.
REQ-024 SERIAL: no pop and no decode; the sequencer SHALL wait for exec_done, then go to IDLE. Fetch pushes remain allowed in this state.
REQ-025 TRAP: trap_req=1 and trap_pc = PC of the faulting instruction, held until flush.
REQ-026 flush, from any state, SHALL clear the FIFO and go to IDLE next cycle; a push in the same cycle is dropped.
REQ-027 flush coincident with an ISSUE handshake: the handshake SHALL count (issue_cnt increments), and the next state SHALL be IDLE.
REQ-028 exec_done outside SERIAL SHALL be ignored.
REQ-029 issue_cnt SHALL increment by 1 per issue handshake and wrap from FFFF_FFFF to 0.
REQ-030 Latency: a push into an empty FIFO in IDLE at edge N SHALL produce DECODE in cycle N+1 and issue_valid in cycle N+2 (issue_ready tied high).
REQ-031 Steady-state rate SHALL be one instruction per 2 cycles for non-serializing instructions.
REQ-032 dec_en SHALL be 0 in every state except DECODE.
REQ-033 dec_instr SHALL hold its last value when dec_en=0.

Reset
REQ-034 On rst_n=0 asynchronously: FSM=IDLE, FIFO empty, fetch_ready=1, dec_en=0, dec_instr=0, issue_valid=0, issue_pc=0, issue_instr=0, trap_req=0, trap_pc=0, issue_cnt=0.
REQ-035 Reset asserted mid-operation SHALL discard all buffered and in-flight state with no further issue.

Structure
REQ-036 The FSM state enum and the BUF_DEPTH constant SHALL reside in a shared cpu_pkg.
REQ-037 The FIFO SHALL be a sub-module, inst_buf, with push/pop/flush/count ports; the FSM and counter SHALL stay in decode_sequencer.

Verification
REQ-038 Push 00000797 (auipc) with decoder responses clean and issue_ready=1 -> issue_valid in cycle N+2 with issue_instr=00000797; issue_cnt=1.
REQ-039 Push 1a5000ef (jal, jmp_op!=0), then 02c78793 -> second instruction not decoded until exec_done pulse; then issued; issue_cnt=2.
REQ-040 Push 00000000 (dec_invalid!=0) at pc=0x200 -> trap_req=1 and trap_pc=0x200 held; flush -> IDLE with trap_req=0.
REQ-041 Hold issue_ready=0 while pushing 3 instructions -> fetch_ready=0 after buffer full; outputs stable; release -> in-order issue.
REQ-042 Assert flush with 2 entries buffered and fetch_valid=1 -> FIFO empty, push dropped, no issue follows.
REQ-043 Preload issue_cnt to FFFF_FFFF via force, issue one instruction -> issue_cnt=0; rst_n pulse mid-ISSUE -> all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU-front-end definitions.
// Provides the decode sequencer state encoding, the instruction buffer
// depth, and a helper that classifies a decoded instruction as serializing.
package cpu_pkg;

    localparam int BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_SERIAL,
        ST_TRAP
    } seq_state_e;

    // Jumps, CSR accesses and machine-level ops must drain before anything
    // younger is decoded.
    function automatic logic is_serializing(input logic [8:0] jmp_op,
                                            input logic [5:0] csr_op,
                                            input logic [7:0] mechie_op);
        return (|jmp_op) || (|csr_op) || (|mechie_op);
    endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// Bundle of the decode sequencer's fetch, decoder, issue and control signals.
// Ports (all members):
//   fetch_valid/fetch_instr/fetch_pc/fetch_ready : fetch-side valid/ready push
//   dec_en/dec_instr                             : decoder enable and instruction
//   dec_invalid/dec_jmp_op/dec_csr_op/dec_mechie_op : decoder classification
//   issue_valid/issue_ready/issue_pc/issue_instr : execute-side handshake
//   exec_done, flush                             : completion and redirect
//   trap_req/trap_pc                             : illegal-instruction report
//   issue_cnt                                    : completed issue handshakes
// Modports: slave = sequencer, master = surrounding pipeline.
interface decode_sequencer_if #(parameter int XLEN = 32);

    logic            fetch_valid;
    logic [XLEN-1:0] fetch_instr;
    logic [XLEN-1:0] fetch_pc;
    logic            fetch_ready;

    logic            dec_en;
    logic [XLEN-1:0] dec_instr;
    logic [31:0]     dec_invalid;
    logic [8:0]      dec_jmp_op;
    logic [5:0]      dec_csr_op;
    logic [7:0]      dec_mechie_op;

    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] issue_pc;
    logic [XLEN-1:0] issue_instr;

    logic            exec_done;
    logic            flush;

    logic            trap_req;
    logic [XLEN-1:0] trap_pc;
    logic [31:0]     issue_cnt;

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc,
        output fetch_ready,
        output dec_en, dec_instr,
        input  dec_invalid, dec_jmp_op, dec_csr_op, dec_mechie_op,
        output issue_valid, issue_pc, issue_instr,
        input  issue_ready,
        input  exec_done, flush,
        output trap_req, trap_pc, issue_cnt
    );

    modport master (
        output fetch_valid, fetch_instr, fetch_pc,
        input  fetch_ready,
        input  dec_en, dec_instr,
        output dec_invalid, dec_jmp_op, dec_csr_op, dec_mechie_op,
        input  issue_valid, issue_pc, issue_instr,
        output issue_ready,
        output exec_done, flush,
        input  trap_req, trap_pc, issue_cnt
    );

endinterface

// File: rtl/inst_buf.sv
// Instruction buffer: small FIFO of {pc, instr} pairs.
// Ports:
//   clk, rst_n             : clock, async active-low reset
//   push_i/push_pc_i/push_instr_i : write one entry (ignored when full)
//   pop_i                  : drop the head entry (ignored when empty)
//   flush_i                : empty the buffer; overrides push and pop
//   head_pc_o/head_instr_o : current head entry (valid when count_o != 0)
//   count_o                : number of occupied entries
module inst_buf
    import cpu_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = BUF_DEPTH,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic [XLEN-1:0] push_pc_i,
    input  logic [XLEN-1:0] push_instr_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] head_pc_o,
    output logic [XLEN-1:0] head_instr_o,
    output logic [CW-1:0]   count_o
);

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (count_q < CW'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Payload storage needs no reset: it is only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            pc_mem_q[wr_ptr_q]    <= push_pc_i;
            instr_mem_q[wr_ptr_q] <= push_instr_i;
        end
    end

    assign head_pc_o    = pc_mem_q[rd_ptr_q];
    assign head_instr_o = instr_mem_q[rd_ptr_q];
    assign count_o      = count_q;

endmodule

// File: rtl/decode_sequencer.sv
// Decode sequencer: takes fetched instructions through a 2-entry buffer,
// runs each through a one-cycle decode, then offers it to execute.
// Serializing instructions block further decode until exec_done; illegal
// instructions park the sequencer in TRAP until flush.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : decode_sequencer_if.slave (fetch, decoder, issue, control)
module decode_sequencer
    import cpu_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BUF_DEPTH = cpu_pkg::BUF_DEPTH
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_sequencer_if.slave   bus
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    seq_state_e      state_q, state_d;
    logic [XLEN-1:0] pc_q, instr_q;
    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic            ser_q, ser_d;
    logic [31:0]     cnt_q;

    logic [CW-1:0]   count;
    logic [XLEN-1:0] head_pc, head_instr;
    logic            push, pop, empty, issue_hs;

    assign bus.fetch_ready = (count < CW'(BUF_DEPTH)) && !bus.flush;
    assign push            = bus.fetch_valid && bus.fetch_ready;
    assign empty           = (count == '0);
    assign issue_hs        = (state_q == ST_ISSUE) && bus.issue_ready;

    inst_buf #(.XLEN(XLEN), .DEPTH(BUF_DEPTH)) u_inst_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_pc_i    (bus.fetch_pc),
        .push_instr_i (bus.fetch_instr),
        .pop_i        (pop),
        .flush_i      (bus.flush),
        .head_pc_o    (head_pc),
        .head_instr_o (head_instr),
        .count_o      (count)
    );

    always_comb begin
        state_d         = state_q;
        ser_d           = ser_q;
        trap_pc_d       = trap_pc_q;
        pop             = 1'b0;
        bus.dec_en      = (state_q == ST_DECODE);
        bus.issue_valid = (state_q == ST_ISSUE);
        bus.trap_req    = (state_q == ST_TRAP);

        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (|bus.dec_invalid) begin
                    state_d   = ST_TRAP;
                    trap_pc_d = pc_q;
                end else begin
                    state_d = ST_ISSUE;
                    ser_d   = is_serializing(bus.dec_jmp_op, bus.dec_csr_op,
                                             bus.dec_mechie_op);
                end
            end
            ST_ISSUE: begin
                if (issue_hs) begin
                    if (ser_q) begin
                        state_d = ST_SERIAL;
                    end else if (!empty) begin
                        // Back-to-back: next instruction goes straight to decode.
                        pop     = 1'b1;
                        state_d = ST_DECODE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_SERIAL: begin
                if (bus.exec_done) state_d = ST_IDLE;
            end
            ST_TRAP: ;
            default: state_d = ST_IDLE;
        endcase

        // Redirect wins over everything; an ISSUE handshake in this cycle
        // still counts because cnt_q follows issue_hs directly.
        if (bus.flush) begin
            state_d   = ST_IDLE;
            pop       = 1'b0;
            ser_d     = ser_q;
            trap_pc_d = trap_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            instr_q   <= '0;
            ser_q     <= 1'b0;
            trap_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ser_q     <= ser_d;
            trap_pc_q <= trap_pc_d;
            if (pop) begin
                pc_q    <= head_pc;
                instr_q <= head_instr;
            end
            if (issue_hs) cnt_q <= cnt_q + 32'd1;
        end
    end

    // The decode register doubles as the issue register: it only reloads on
    // a pop, which never happens while an instruction is being offered.
    assign bus.dec_instr   = instr_q;
    assign bus.issue_pc    = pc_q;
    assign bus.issue_instr = instr_q;
    assign bus.trap_pc     = trap_pc_q;
    assign bus.issue_cnt   = cnt_q;

endmodule
